// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the 8N1 UART receive path: frame size, FSM states and the
// oversample divider formula (also used by the transmit side).
package uart_receiver_pkg;

    localparam int FRAME_DATA_BITS    = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    function automatic int tick_divisor(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_receiver_oversample_tick.sv
// Oversample tick generator: free-running 0..DIV-1 divider, one-cycle tick on wrap.
// restart_i re-phases the divider so bit sampling lines up with the start edge.
module uart_receiver_oversample_tick #(
    parameter int DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                          cnt_q <= '0;
        else if (restart_i || cnt_q == LAST) cnt_q <= '0;
        else                                cnt_q <= cnt_q + CW'(1);
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes the line, majority-samples each bit mid-way and
// hands completed bytes over a held valid/taken handshake with framing/overrun pulses.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       data_taken,
    output logic [FRAME_DATA_BITS-1:0] data_out,
    output logic                       data_valid,
    output logic                       framing_error,
    output logic                       overrun,
    output logic                       busy
);
    localparam int DIV = tick_divisor(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(FRAME_DATA_BITS);

    localparam logic [SW-1:0] S_LO     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_DATA_BITS - 1);

    rx_state_e                  state_q;
    logic                       sync_q, rx_s_q, rx_prev_q;
    logic [SW-1:0]              s_q;
    logic [BW-1:0]              bit_q;
    logic [1:0]                 samp_q;
    logic [FRAME_DATA_BITS-1:0] shift_q, data_q;
    logic                       valid_q, ferr_q, ovr_q, busy_q;

    logic tick, start_edge, decide, bit_end, bit_d;

    assign start_edge = (state_q == ST_IDLE) && rx_prev_q && !rx_s_q;
    assign decide     = tick && (s_q == S_DEC);
    assign bit_end    = tick && (s_q == S_END);
    // Two early samples plus the live one at the decision tick form the 2-of-3 vote.
    assign bit_d      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    uart_receiver_oversample_tick #(.DIV(DIV)) u_tick (
        .clock     (clock),
        .reset     (reset),
        .restart_i (start_edge),
        .tick_o    (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            s_q       <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= data_in;
            rx_s_q    <= sync_q;
            rx_prev_q <= rx_s_q;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            if (data_taken) valid_q <= 1'b0;
            if (tick) begin
                if (s_q == S_LO)  samp_q[0] <= rx_s_q;
                if (s_q == S_MID) samp_q[1] <= rx_s_q;
                s_q <= (s_q == S_END) ? '0 : s_q + SW'(1);
            end
            case (state_q)
                ST_IDLE: if (start_edge) begin
                    state_q <= ST_START;
                    busy_q  <= 1'b1;
                    s_q     <= '0;
                end
                ST_START: begin
                    if (decide && bit_d) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (bit_end) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (decide) shift_q <= {bit_d, shift_q[FRAME_DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_q == LAST_BIT) state_q <= ST_STOP;
                        bit_q <= bit_q + BW'(1);
                    end
                end
                // Leaving at stop mid-point lets a following start bit be caught with no idle gap.
                ST_STOP: if (decide) begin
                    busy_q <= 1'b0;
                    if (!bit_d) begin
                        ferr_q  <= 1'b1;
                        state_q <= ST_BREAK;
                    end else begin
                        state_q <= ST_IDLE;
                        if (!valid_q || data_taken) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
                ST_BREAK: if (rx_s_q) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: reset, latency, glitch, table of frames,
// overrun, same-cycle take, mid-frame reset, then random frames against a frame-level model.
module tb_uart_receiver;
    localparam int BIT_CLK = 160;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b1;
    logic       data_taken;
    logic [7:0] data_out;
    logic       data_valid, framing_error, overrun, busy;

    logic auto_take = 1'b0;
    logic man_take  = 1'b0;
    assign data_taken = auto_take ? data_valid : man_take;

    uart_receiver #(
        .CLOCK_FREQ (1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .data_taken    (data_taken),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, busy_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clock) begin
        if (framing_error) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (framing_error && overrun) both_cnt++;
        if (busy) busy_cnt++;
        if (auto_take && data_valid) got_q.push_back(data_out);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller must be sitting on a negedge; every bit is held for BIT_CLK clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        data_in = 1'b0;
        repeat (BIT_CLK) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            data_in = b[i];
            repeat (BIT_CLK) @(negedge clock);
        end
        data_in = stop;
        repeat (BIT_CLK) @(negedge clock);
    endtask

    task automatic take_pulse();
        man_take = 1'b1;
        @(negedge clock);
        man_take = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[5];
    int   f0, o0, b0;
    logic [7:0] rb;
    logic       rstop;

    initial begin
        tbl[0] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
        tbl[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 0};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        tbl[4] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1};

        // Reset values
        repeat (5) @(negedge clock);
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_ferr", 32'(framing_error), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (2000) @(negedge clock);
        chk("idle_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("idle_ferr", 32'(ferr_cnt), 32'd0);
        chk("idle_ovr", 32'(ovr_cnt), 32'd0);
        chk("idle_valid", 32'(data_valid), 32'h0);

        // 0xA5 with latency: load lands 1542 clocks after the start bit is driven
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (1542) @(negedge clock);
                chk("a5_valid_before", 32'(data_valid), 32'h0);
                chk("a5_busy_before", 32'(busy), 32'h1);
                @(negedge clock);
                chk("a5_valid_after", 32'(data_valid), 32'h1);
                chk("a5_data", 32'(data_out), 32'hA5);
                chk("a5_busy_after", 32'(busy), 32'h0);
            end
        join
        take_pulse();
        chk("a5_taken_valid", 32'(data_valid), 32'h0);

        // Start-bit glitch
        f0 = ferr_cnt; o0 = ovr_cnt;
        data_in = 1'b0;
        repeat (20) @(negedge clock);
        chk("glitch_busy_high", 32'(busy), 32'h1);
        repeat (20) @(negedge clock);
        data_in = 1'b1;
        repeat (200) @(negedge clock);
        chk("glitch_busy_low", 32'(busy), 32'h0);
        chk("glitch_valid", 32'(data_valid), 32'h0);
        chk("glitch_flags", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);

        // Table of frames, one at a time with explicit take
        for (int i = 0; i < 5; i++) begin
            f0 = ferr_cnt;
            send_frame(tbl[i].b, tbl[i].stop);
            if (!tbl[i].stop) begin
                repeat (500) @(negedge clock);
                chk($sformatf("tbl%0d_busy_in_break", i), 32'(busy), 32'h0);
            end else begin
                repeat (5) @(negedge clock);
            end
            chk($sformatf("tbl%0d_valid", i), 32'(data_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_ferr", i), 32'(ferr_cnt - f0), 32'(tbl[i].exp_ferr));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].exp_data));
                take_pulse();
                chk($sformatf("tbl%0d_taken", i), 32'(data_valid), 32'h0);
            end
            data_in = 1'b1;
            repeat (20) @(negedge clock);
        end

        // Overrun: 0x01 then 0x02 back-to-back, nobody consumes
        o0 = ovr_cnt; f0 = ferr_cnt;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        repeat (5) @(negedge clock);
        chk("ovr_data_kept", 32'(data_out), 32'h01);
        chk("ovr_valid", 32'(data_valid), 32'h1);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        take_pulse();
        repeat (20) @(negedge clock);

        // 0x55, 0xAA back-to-back, take in the exact cycle 0xAA loads
        o0 = ovr_cnt;
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'hAA, 1'b1);
            end
            begin
                repeat (1600 + 1542) @(negedge clock);
                chk("same_cycle_old", 32'(data_out), 32'h55);
                man_take = 1'b1;
                @(negedge clock);
                man_take = 1'b0;
                chk("same_cycle_valid", 32'(data_valid), 32'h1);
                chk("same_cycle_data", 32'(data_out), 32'hAA);
                repeat (10) @(negedge clock);
                chk("same_cycle_hold", 32'(data_valid), 32'h1);
            end
        join
        chk("same_cycle_no_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Reset in the middle of a third frame
        f0 = ferr_cnt; o0 = ovr_cnt;
        data_in = 1'b0;
        repeat (BIT_CLK) @(negedge clock);
        data_in = 1'b1;
        repeat (200) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("midrst_data", 32'(data_out), 32'h00);
        chk("midrst_valid", 32'(data_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (2000) @(negedge clock);
        chk("midrst_after_busy", 32'(busy), 32'h0);
        chk("midrst_after_valid", 32'(data_valid), 32'h0);
        chk("midrst_flags", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);

        // Random frames; model: good stop -> byte delivered in order, bad stop -> one framing error
        got_q.delete();
        exp_q.delete();
        f0 = 0; b0 = ferr_cnt; o0 = ovr_cnt;
        auto_take = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(4) != 0);
            send_frame(rb, rstop);
            if (rstop) begin
                exp_q.push_back(rb);
                repeat ($urandom_range(40)) @(negedge clock);
            end else begin
                f0++;
                repeat (200 + $urandom_range(100)) @(negedge clock);
                data_in = 1'b1;
                repeat (10 + $urandom_range(30)) @(negedge clock);
            end
        end
        data_in = 1'b1;
        repeat (50) @(negedge clock);
        auto_take = 1'b0;
        chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("rand_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("rand_ferr", 32'(ferr_cnt - b0), 32'(f0));
        chk("rand_ovr", 32'(ovr_cnt - o0), 32'd0);
        chk("flags_never_both", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
